// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the parametrised control sequencer:
// sequencer states, control-word bit map, opcodes and per-opcode instruction length.
package ctrl_seq_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    // Control word bit map (one bit per datapath strobe)
    localparam int unsigned CTRL_BITS = 12;
    localparam int unsigned PC_INC    = 0;
    localparam int unsigned PC_OE     = 1;
    localparam int unsigned MAR_LD    = 2;
    localparam int unsigned RAM_OE    = 3;
    localparam int unsigned IR_LD     = 4;
    localparam int unsigned IR_OE     = 5;
    localparam int unsigned A_LD      = 6;
    localparam int unsigned A_OE      = 7;
    localparam int unsigned B_LD      = 8;
    localparam int unsigned ALU_OE    = 9;
    localparam int unsigned ALU_SUB   = 10;
    localparam int unsigned OUT_LD    = 11;

    // Opcodes (low four opcode bits)
    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_LDI = 4'd3;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    // Last fetch T-state; execution starts at the T-state after it
    localparam int unsigned FETCH_LAST_T = 2;

    // One-hot control word with a single strobe set
    function automatic logic [CTRL_BITS-1:0] cbit(input int unsigned idx);
        logic [CTRL_BITS-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

    // Final T-state of an instruction, by opcode
    function automatic int unsigned last_t_of(input logic [3:0] op);
        case (op)
            OP_LDA:         return 4;
            OP_ADD, OP_SUB: return 5;
            default:        return 3;
        endcase
    endfunction

endpackage

// File: rtl/param_control_sequencer_ctrl_decode_rom.sv
// Combinational microcode ROM: {opcode, t_state} -> {control word, last T-state flag}.
// Fetch microcode (T0..T2) is opcode independent; opcodes with any bit above
// bit 3 set decode as NOP.
module ctrl_decode_rom
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int T_W      = 3
) (
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic [T_W-1:0]       t_state,
    output logic [CTRL_BITS-1:0] ctrl,
    output logic                 last_t
);

    logic [3:0] op;
    logic       high_set;
    logic [3:0] op_eff;

    // Split the opcode into the compared nibble and the must-be-zero upper bits
    always_comb begin
        op       = opcode[3:0];
        high_set = |(opcode >> 4);
        op_eff   = high_set ? 4'd4 : op;  // 4 is an unused opcode, i.e. NOP
    end

    // Microcode lookup
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        ctrl   = '0;
        last_t = 1'b0;
        if (t_state == T_W'(0)) begin
            ctrl = cbit(PC_OE) | cbit(MAR_LD);
        end else if (t_state == T_W'(1)) begin
            ctrl = cbit(PC_INC);
        end else if (t_state == T_W'(FETCH_LAST_T)) begin
            ctrl = cbit(RAM_OE) | cbit(IR_LD);
        end else begin
            last_t = (t_state >= T_W'(last_t_of(op_eff)));
            case (op_eff)
                OP_LDA: begin
                    if (t_state == T_W'(3))      ctrl = cbit(IR_OE) | cbit(MAR_LD);
                    else if (t_state == T_W'(4)) ctrl = cbit(RAM_OE) | cbit(A_LD);
                end
                OP_ADD, OP_SUB: begin
                    if (t_state == T_W'(3))      ctrl = cbit(IR_OE) | cbit(MAR_LD);
                    else if (t_state == T_W'(4)) ctrl = cbit(RAM_OE) | cbit(B_LD);
                    else if (t_state == T_W'(5)) begin
                        ctrl = cbit(ALU_OE) | cbit(A_LD);
                        if (op_eff == OP_SUB) ctrl = ctrl | cbit(ALU_SUB);
                    end
                end
                OP_LDI: begin
                    if (t_state == T_W'(3)) ctrl = cbit(IR_OE) | cbit(A_LD);
                end
                OP_OUT: begin
                    if (t_state == T_W'(3)) ctrl = cbit(A_OE) | cbit(OUT_LD);
                end
                default: ctrl = '0;  // HLT and NOP drive no datapath strobes
            endcase
        end
    end

endmodule

// File: rtl/param_control_sequencer.sv
// Control sequencer for the 8-bit datapath: ring T-state counter, FETCH/EXEC/HALT
// FSM, memory-ready stall, single-step and enable gating. Control word is
// combinational from the registered state, T-state and the IR opcode.
module param_control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int NUM_T    = 6,
    parameter int CTRL_W   = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     step_mode,
    input  logic                     step,
    input  logic                     mem_ready,
    input  logic                     resume,
    input  logic [OPCODE_W-1:0]      opcode,
    output logic [CTRL_W-1:0]        ctrl,
    output logic [$clog2(NUM_T)-1:0] t_state,
    output logic                     halted,
    output logic                     instr_done
);

    localparam int T_W = $clog2(NUM_T);

    generate
        if (OPCODE_W < 4) begin : g_bad_opcode_w
            $error("param_control_sequencer: OPCODE_W must be >= 4");
        end
        if (NUM_T < 6) begin : g_bad_num_t
            $error("param_control_sequencer: NUM_T must be >= 6");
        end
        if (CTRL_W != CTRL_BITS) begin : g_bad_ctrl_w
            $error("param_control_sequencer: CTRL_W must match the control bit map");
        end
    endgenerate

    seq_state_t           state, state_next;
    logic [T_W-1:0]       t_q, t_next;
    logic [CTRL_BITS-1:0] rom_ctrl, ctrl_int;
    logic                 rom_last, last, stall, adv, hlt_op, done;

    ctrl_decode_rom #(
        .OPCODE_W (OPCODE_W),
        .T_W      (T_W)
    ) u_rom (
        .opcode  (opcode),
        .t_state (t_q),
        .ctrl    (rom_ctrl),
        .last_t  (rom_last)
    );

    // Advance qualification: microcode only in FETCH/EXEC, RAM stall beats step
    always_comb begin
        ctrl_int = (state == FETCH || state == EXEC) ? rom_ctrl : '0;
        stall    = ctrl_int[RAM_OE] & ~mem_ready;
        adv      = ena & (step_mode ? step : 1'b1) & ~stall;
        last     = rom_last | (t_q == T_W'(NUM_T - 1));
        hlt_op   = (opcode[3:0] == OP_HLT) && ((opcode >> 4) == '0);
    end

    // Next-state and T-state sequencing
    always_comb begin
        state_next = state;
        t_next     = t_q;
        done       = 1'b0;
        case (state)
            RESET: begin
                if (adv) begin
                    state_next = FETCH;
                    t_next     = '0;
                end
            end
            FETCH: begin
                if (adv) begin
                    if (t_q == T_W'(FETCH_LAST_T)) state_next = EXEC;
                    t_next = t_q + T_W'(1);
                end
            end
            EXEC: begin
                if (adv) begin
                    if (last) begin
                        t_next     = '0;
                        done       = 1'b1;
                        state_next = hlt_op ? HALT : FETCH;
                    end else begin
                        t_next = t_q + T_W'(1);
                    end
                end
            end
            HALT: begin
                // Only resume (with enable) leaves HALT; step and mem_ready are ignored
                t_next = '0;
                if (ena && resume) state_next = FETCH;
            end
            default: begin
                state_next = RESET;
                t_next     = '0;
            end
        endcase
    end

    // State and T-state registers; reset aborts any instruction immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET;
            t_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= state_next;
            t_q   <= t_next;
        end
    end

    // Output drive: enable low forces an all-zero control word
    always_comb begin
        ctrl       = ena ? CTRL_W'(ctrl_int) : '0;
        t_state    = t_q;
        halted     = (state == HALT);
        instr_done = done;
    end

endmodule

// File: tb/tb_param_control_sequencer.sv
// Scoreboard bench: stimulus pushes the hand-computed expected outputs for each
// cycle; a separate monitor pops and compares them away from the clock edge.
module tb_param_control_sequencer;

    // Hand-computed control words (bit map: PC_INC=0 PC_OE=1 MAR_LD=2 RAM_OE=3
    // IR_LD=4 IR_OE=5 A_LD=6 A_OE=7 B_LD=8 ALU_OE=9 ALU_SUB=10 OUT_LD=11)
    localparam logic [11:0] C_NONE   = 12'h000;
    localparam logic [11:0] C_T0     = 12'h006;  // PC_OE|MAR_LD
    localparam logic [11:0] C_T1     = 12'h001;  // PC_INC
    localparam logic [11:0] C_T2     = 12'h018;  // RAM_OE|IR_LD
    localparam logic [11:0] C_IRMAR  = 12'h024;  // IR_OE|MAR_LD
    localparam logic [11:0] C_RAMA   = 12'h048;  // RAM_OE|A_LD
    localparam logic [11:0] C_RAMB   = 12'h108;  // RAM_OE|B_LD
    localparam logic [11:0] C_ALUSUB = 12'h640;  // ALU_OE|A_LD|ALU_SUB
    localparam logic [11:0] C_LDI    = 12'h060;  // IR_OE|A_LD
    localparam logic [11:0] C_OUT    = 12'h880;  // A_OE|OUT_LD

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst6_n = 1'b0;
    logic       ena = 1'b1;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic       mem_ready = 1'b1;
    logic       resume = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic [5:0] opcode6 = 6'b010000;

    logic [11:0] ctrl4, ctrl6;
    logic [2:0]  t4, t6;
    logic        halted4, halted6, done4, done6;

    param_control_sequencer #(.OPCODE_W(4), .NUM_T(6), .CTRL_W(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .step_mode  (step_mode),
        .step       (step),
        .mem_ready  (mem_ready),
        .resume     (resume),
        .opcode     (opcode),
        .ctrl       (ctrl4),
        .t_state    (t4),
        .halted     (halted4),
        .instr_done (done4)
    );

    param_control_sequencer #(.OPCODE_W(6), .NUM_T(6), .CTRL_W(12)) dut6 (
        .clk        (clk),
        .rst_n      (rst6_n),
        .ena        (ena),
        .step_mode  (step_mode),
        .step       (step),
        .mem_ready  (mem_ready),
        .resume     (resume),
        .opcode     (opcode6),
        .ctrl       (ctrl6),
        .t_state    (t6),
        .halted     (halted6),
        .instr_done (done6)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         sel;     // 0: 4-bit opcode instance, 1: 6-bit opcode instance
        logic [11:0] ctrl;
        logic [2:0] t;
        logic       halted;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string nm, input logic [16:0] got, input logic [16:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got ctrl=%h t=%0d halted=%b done=%b, expected ctrl=%h t=%0d halted=%b done=%b",
                     nm, got[16:5], got[4:2], got[1], got[0], want[16:5], want[4:2], want[1], want[0]);
        end
    endtask

    // Monitor: compares on each falling clock edge and right after an async reset
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.sel)
                    check(e.name, {ctrl6, t6, halted6, done6}, {e.ctrl, e.t, e.halted, e.done});
                else
                    check(e.name, {ctrl4, t4, halted4, done4}, {e.ctrl, e.t, e.halted, e.done});
            end
        end
    end

    task automatic push_exp(input string nm, input bit sel, input logic [11:0] c,
                            input int t, input logic h, input logic d);
        exp_t e;
        e.name   = nm;
        e.sel    = sel;
        e.ctrl   = c;
        e.t      = 3'(t);
        e.halted = h;
        e.done   = d;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect outputs for the current cycle of the main instance, then advance one clock
    task automatic cyc(input string nm, input logic [11:0] c, input int t,
                       input logic h, input logic d);
        push_exp(nm, 1'b0, c, t, h, d);
        tick();
    endtask

    task automatic cyc6(input string nm, input logic [11:0] c, input int t, input logic d);
        push_exp(nm, 1'b1, c, t, 1'b0, d);
        tick();
    endtask

    initial begin
        tick();
        // Reset and release
        cyc("reset", C_NONE, 0, 0, 0);
        rst_n = 1'b1;
        cyc("reset_release", C_NONE, 0, 0, 0);

        // LDA: T0..T4
        opcode = 4'd0;
        cyc("lda_t0", C_T0, 0, 0, 0);
        cyc("lda_t1", C_T1, 1, 0, 0);
        cyc("lda_t2", C_T2, 2, 0, 0);
        cyc("lda_t3", C_IRMAR, 3, 0, 0);
        cyc("lda_t4", C_RAMA, 4, 0, 1);

        // SUB: T0..T5
        opcode = 4'd2;
        cyc("sub_t0", C_T0, 0, 0, 0);
        cyc("sub_t1", C_T1, 1, 0, 0);
        cyc("sub_t2", C_T2, 2, 0, 0);
        cyc("sub_t3", C_IRMAR, 3, 0, 0);
        cyc("sub_t4", C_RAMB, 4, 0, 0);
        cyc("sub_t5", C_ALUSUB, 5, 0, 1);

        // LDI with a three-cycle memory stall at T2
        opcode = 4'd3;
        cyc("ldi_t0", C_T0, 0, 0, 0);
        cyc("ldi_t1", C_T1, 1, 0, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("stall_t2", C_T2, 2, 0, 0);
        mem_ready = 1'b1;
        cyc("ldi_t2", C_T2, 2, 0, 0);
        cyc("ldi_t3", C_LDI, 3, 0, 1);

        // OUT with enable dropped for two cycles at T2
        opcode = 4'd14;
        cyc("out_t0", C_T0, 0, 0, 0);
        cyc("out_t1", C_T1, 1, 0, 0);
        ena = 1'b0;
        cyc("ena_off_a", C_NONE, 2, 0, 0);
        cyc("ena_off_b", C_NONE, 2, 0, 0);
        ena = 1'b1;
        cyc("out_t2", C_T2, 2, 0, 0);
        cyc("out_t3", C_OUT, 3, 0, 1);

        // ADD in single-step mode, step every 4th cycle
        opcode    = 4'd1;
        step_mode = 1'b1;
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 4; k++) begin
                step = (k == 3);
                cyc("step_fetch", (t == 0) ? C_T0 : C_T1, t, 0, 0);
            end
        end
        step      = 1'b1;
        mem_ready = 1'b0;
        cyc("step_with_stall", C_T2, 2, 0, 0);
        step      = 1'b0;
        mem_ready = 1'b1;
        cyc("step_no_pulse", C_T2, 2, 0, 0);
        step = 1'b1;
        cyc("step_t2", C_T2, 2, 0, 0);
        step      = 1'b0;
        step_mode = 1'b0;
        cyc("add_t3", C_IRMAR, 3, 0, 0);

        // Reset asserted asynchronously in ADD T4
        push_exp("add_t4", 1'b0, C_RAMB, 4, 0, 0);
        #7;
        rst_n = 1'b0;
        push_exp("async_reset", 1'b0, C_NONE, 0, 0, 0);
        tick();
        cyc("reset_hold", C_NONE, 0, 0, 0);
        rst_n = 1'b1;
        cyc("reset_release2", C_NONE, 0, 0, 0);

        // HLT, then resume
        opcode = 4'd15;
        cyc("hlt_t0", C_T0, 0, 0, 0);
        cyc("hlt_t1", C_T1, 1, 0, 0);
        cyc("hlt_t2", C_T2, 2, 0, 0);
        cyc("hlt_t3", C_NONE, 3, 0, 1);
        mem_ready = 1'b0;
        cyc("halted", C_NONE, 0, 1, 0);
        ena    = 1'b0;
        resume = 1'b1;
        cyc("resume_no_ena", C_NONE, 0, 1, 0);
        ena       = 1'b1;
        step_mode = 1'b1;
        step      = 1'b1;
        cyc("resume", C_NONE, 0, 1, 0);
        resume    = 1'b0;
        step      = 1'b0;
        mem_ready = 1'b1;
        cyc("resume_fetch_t0", C_T0, 0, 0, 0);
        step_mode = 1'b0;

        // 6-bit opcode instance: 6'b010000 decodes as NOP ending at T3
        rst6_n = 1'b1;
        cyc6("w6_reset_release", C_NONE, 0, 0);
        cyc6("w6_t0", C_T0, 0, 0);
        cyc6("w6_t1", C_T1, 1, 0);
        cyc6("w6_t2", C_T2, 2, 0);
        cyc6("w6_t3_nop", C_NONE, 3, 1);
        cyc6("w6_next_t0", C_T0, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
